gray_counter: RTL
=================

# gray_counter

Synchronous up/down counter that holds a binary count and its reflected Gray-code equivalent in registers. It sits directly upstream of any Gray-code consumer: it supplies the stepping binary value that binary-to-Gray conversion acts on, and it registers the Gray word so downstream logic sees exactly one bit change per step with no glitches. It also supports loading a Gray-coded value, which it decodes back to binary. This lets the block resume from a Gray snapshot.

## Interface

Parameters:
- WIDTH, 4, counter width in bits (min 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  advance the count by one step this cycle
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  load load_gray this cycle
- load_gray  input  WIDTH  Gray-coded value to load
- B  output  WIDTH  registered binary count
- G  output  WIDTH  registered Gray code of B, always equal to B ^ (B >> 1)
- wrap  output  1  one-cycle pulse on a terminal-count wrap

Clock and reset are fixed: one clock, clk. Reset is synchronous and active-low on rst_n.

## Operation

- Priority per rising clk edge: reset, then load, then en, then hold.
- Reset (rst_n = 0): B = 0, G = 0, wrap = 0.
- Load (load = 1):
  - G <= load_gray.
  - B <= gray-to-binary(load_gray), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
  - wrap <= 0.
  - en and up_dn are ignored in a load cycle.
- Count (en = 1, load = 0):
  - Next B = B + 1 when up_dn = 1, or B - 1 when up_dn = 0, modulo 2^WIDTH.
  - Next G = next B ^ (next B >> 1), computed from the next value, not the current one.
- Hold (en = 0, load = 0): B and G are unchanged and wrap = 0.
- Wrap:
  - wrap = 1 for exactly the cycle after a step from all-ones to 0 with up_dn = 1.
  - wrap = 1 for exactly the cycle after a step from 0 to all-ones with up_dn = 0.
  - wrap = 0 in every other case, including a load whose value equals a terminal count.
- Invariant: G == B ^ (B >> 1) holds after every edge. Between consecutive counting cycles, G differs in exactly one bit.
- Arithmetic:
  - Unsigned only, WIDTH bits, no carry output.
  - A direction change takes effect on the same edge it is presented. There is no pipeline to drain.

## Timing

- Latency: one clock from input to B, G and wrap. All outputs are registered, and there is no combinational path from input to output.
- B and G update on the same edge and are never skewed.
- Reset mid-count: outputs read 0 after the edge where rst_n = 0, regardless of en or load.
- Counting resumes on the first edge with rst_n = 1.
- Asserting en continuously gives one step per clock. There is no handshake or back-pressure.

## Structure

- Shared package gray_pkg:
  - GRAY_WIDTH_DEFAULT = 4.
  - bin2gray and gray2bin functions, parameterized by width.
  - These are reused by neighbouring Gray-code blocks.
- Sub-module gray_to_binary: purely combinational WIDTH-bit decoder on the load path, instantiated once.
- Next-state logic (increment/decrement mux, wrap detect) and the output registers are implemented inline in gray_counter.

## Test plan

- Reset: assert rst_n = 0 for 2 cycles with en = 1. Required: B = 0, G = 0, wrap = 0 throughout.
- Count up, WIDTH = 4, en = 1, up_dn = 1, 16 cycles from 0. Required:
  - G sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0.
  - wrap = 1 only in the cycle B returns to 0.
  - Exactly one G bit changes per step.
- Count down from 0: one step with up_dn = 0. Required: B = F, G = 8, wrap = 1. A second step gives B = E, G = 9, wrap = 0.
- Load versus enable: load = 1, load_gray = C, en = 1 in the same cycle. Required: B = 8, G = C, wrap = 0. The next en up-step gives B = 9, G = D.
- Hold then reset mid-count:
  - Count to B = 5, then en = 0 for 3 cycles. Required: B = 5 and G = 7 stable.
  - Then rst_n = 0 for 1 cycle with en = 1. Required: B = 0 and G = 0 on the next edge.
- Parameter check at WIDTH = 8, counting up. Required: at B = 7F, G = 40. The next step gives B = 80, G = C0. FF to 00 pulses wrap.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for gray_counter and neighbouring Gray-code blocks.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH_DEFAULT = 4;
    localparam int unsigned GRAY_MAX_WIDTH     = 64;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    // Callers zero-extend narrower words and truncate the result.
    // Leading zeros leave both conversions unaffected, so one function serves every width.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = '0;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int unsigned i = 1; i < GRAY_MAX_WIDTH; i++) begin
            b[GRAY_MAX_WIDTH-1-i] = b[GRAY_MAX_WIDTH-i] ^ g[GRAY_MAX_WIDTH-1-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational WIDTH-bit Gray-to-binary decoder used on the counter's load path.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int unsigned i = 0; i < WIDTH-1; i++) begin
            bin[WIDTH-2-i] = bin[WIDTH-1-i] ^ gray[WIDTH-2-i];
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter that registers a binary count, its Gray code, and a terminal-count wrap pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] G,
    output logic             wrap
);

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] next_b;
    logic [WIDTH-1:0] next_g;
    logic             step_wrap;

    gray_to_binary #(.WIDTH(WIDTH)) u_load_decode (
        .gray (load_gray),
        .bin  (load_bin)
    );

    // The Gray word is derived from the next binary value, so B and G are always updated together.
    always_comb begin
        next_b    = up_dn ? (B + WIDTH'(1)) : (B - WIDTH'(1));
        next_g    = WIDTH'(bin2gray(gray_word_t'(next_b)));
        step_wrap = up_dn ? (B == '1) : (B == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            B    <= '0;
            G    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            B    <= load_bin;
            G    <= load_gray;
            wrap <= 1'b0;
        end else if (en) begin
            B    <= next_b;
            G    <= next_g;
            wrap <= step_wrap;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
